// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder with a three-state controller.
//
// A single full-adder cell (two half adders and an OR) is reused once per
// bit, LSB first, so an addition takes WIDTH cycles in RUN. The result is
// {carry, sum} = a + b + cin, modulo 2^(WIDTH+1).
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the ovf output
// (two's-complement overflow, registered together with sum). The default
// build, with the macro undefined, has no ovf port and no ovf logic.
//
// Handshake: start is a request that is accepted only when the controller
// is in IDLE or DONE. a, b and cin are sampled on the accepting edge only.
// busy is high for exactly WIDTH cycles after that edge. The cycle after
// that, done is high for one cycle and sum/carry(/ovf) hold the new
// result. start may be held high in the done cycle to chain operations
// with no idle gap. start is ignored while busy.
//
// state_o exposes the controller state (0 = IDLE, 1 = RUN, 2 = DONE).

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_o
);

  // The counter only needs to reach WIDTH-1; WIDTH is at least 2.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand A shift register
  logic [WIDTH-1:0] b_q, b_d;      // operand B shift register
  logic             c_q, c_d;      // running carry
  logic [WIDTH-1:0] res_q, res_d;  // result shift register, filled from MSB
  logic [CW-1:0]    cnt_q, cnt_d;  // index of the bit being added
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  // Bit-serial adder cell acting on the operand LSBs and the running carry.
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    fa_s  = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_c  = ha1_c | ha2_c;
  end

  // Next-state, datapath and registered-output logic for the controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = fa_c;
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the completed result on the DONE-entry edge.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          carry_d = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // Overflow: carry into the MSB differs from carry out of it.
          ovf_d   = c_q ^ fa_c;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the controller, datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign carry   = carry_q;
  assign state_o = state_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl at WIDTH=8.
// Define SERIAL_ADD_OVF_EN for both bench and design to cover the ovf port.

module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, carry;
  logic [W-1:0] sum;
  logic [1:0]   state_o;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .carry   (carry),
`ifdef SERIAL_ADD_OVF_EN
    .ovf     (ovf),
`endif
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One complete addition: start in cycle 0, busy in cycles 1..8, done in 9.
  task automatic run_vec(input vec_t v, input logic [W-1:0] ps, input logic pc);
    logic lat_ok, hold_ok;
    logic [W-1:0] exp_s;
    exp_q.push_back(v.s);
    @(negedge clk);
    start = 1'b1; a = v.a; b = v.b; cin = v.cin;
    lat_ok  = 1'b1;
    hold_ok = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
      if (sum !== ps || carry !== pc) hold_ok = 1'b0;
      start = 1'b0;
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    if (done !== 1'b1 || busy !== 1'b0) lat_ok = 1'b0;
    exp_s = exp_q.pop_front();
    check("latency", {31'd0, lat_ok}, 32'd1);
    check("hold_prev_result", {31'd0, hold_ok}, 32'd1);
    check("sum", {24'd0, sum}, {24'd0, exp_s});
    check("carry", {31'd0, carry}, {31'd0, v.c});
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", {31'd0, ovf}, {31'd0, v.o});
`endif
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("back_to_idle", {30'd0, state_o}, {30'd0, ST_IDLE});
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] ps;
    logic         pc;
    logic [W-1:0] got;
    int           n_done;
    logic         seen;
    vec_t         v;

    //                a      b      cin   sum    carry ovf
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[8] = '{8'h01, 8'h7F, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[9] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;

    // Table of additions, each checked for latency, hold and result.
    ps = '0;
    pc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], ps, pc);
      ps = vecs[i].s;
      pc = vecs[i].c;
    end

    // start pulsed and operands changed mid-RUN: one done, first operands.
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    n_done = 0;
    got = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        got = sum;
      end
      case (k)
        1: start = 1'b0;
        3: begin start = 1'b1; a = 8'h77; b = 8'h33; cin = 1'b1; end
        4: begin start = 1'b0; a = 8'hF0; b = 8'h0F; end
        default: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
      endcase
    end
    check("midrun_done_count", n_done, 32'd1);
    check("midrun_sum", {24'd0, got}, 32'h30);

    // start held in the DONE cycle: back-to-back with no idle gap.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_sum", {24'd0, sum}, 32'h03);
    start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0;
    @(negedge clk);
    check("b2b_busy_next", {31'd0, busy}, 32'd1);
    check("b2b_state_run", {30'd0, state_o}, {30'd0, ST_RUN});
    start = 1'b0; a = 8'hAA; b = 8'hBB;
    for (int k = 2; k <= W + 1; k++) @(negedge clk);
    check("b2b_second_done", {31'd0, done}, 32'd1);
    check("b2b_second_sum", {24'd0, sum}, 32'h08);
    @(negedge clk);
    check("b2b_done_drop", {31'd0, done}, 32'd0);

    // Reset in the 4th RUN cycle abandons the addition.
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum", {24'd0, sum}, 32'd0);
    check("midrst_carry", {31'd0, carry}, 32'd0);
    check("midrst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    check("no_done_after_rst", {31'd0, seen}, 32'd0);
    v = '{8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0};
    run_vec(v, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
